// File: rtl/branch_predictor_if.sv
// Fetch-side and execute-side signals of the branch predictor.
// The pipeline (master) drives the fetch PC and the branch resolution.
// The predictor (slave) returns the prediction, the flush request and the
// statistics counters.
interface branch_predictor_if;
  // IF-stage lookup
  logic [31:0] pc_if;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_next_pc;

  // EX-stage training and flush
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic        update_pred_taken;
  logic [31:0] update_pred_target;
  logic        mispredict;
  logic [31:0] correct_pc;

  // Statistics
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  modport master (
    output pc_if, update_valid, update_pc, update_taken, update_target,
           update_pred_taken, update_pred_target,
    input  pred_hit, pred_taken, pred_next_pc, mispredict, correct_pc,
           branch_count, mispredict_count
  );

  modport slave (
    input  pc_if, update_valid, update_pc, update_taken, update_target,
           update_pred_taken, update_pred_target,
    output pred_hit, pred_taken, pred_next_pc, mispredict, correct_pc,
           branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters for the IF stage.
// Lookup is combinational on pc_if; training happens on the clock edge on
// which EX presents a resolved conditional branch. Mispredictions are
// flagged combinationally in the EX cycle together with the refetch PC.
module branch_predictor #(
  parameter int         INDEX_BITS = 4,
  parameter int         TAG_BITS   = 32 - INDEX_BITS - 2,
  parameter logic [1:0] CNT_ALLOC  = 2'b10
) (
  input  logic           clock,
  input  logic           reset,
  branch_predictor_if.slave bp
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic [31:0]         target;
    logic [1:0]          cnt;
  } btb_entry_t;

  btb_entry_t table_q [ENTRIES];

  logic [INDEX_BITS-1:0] look_idx;
  logic [TAG_BITS-1:0]   look_tag;
  btb_entry_t            look_e;
  logic                  look_hit;
  logic                  look_taken;

  logic [INDEX_BITS-1:0] upd_idx;
  logic [TAG_BITS-1:0]   upd_tag;
  btb_entry_t            upd_e;
  btb_entry_t            upd_next;
  logic                  upd_hit;
  logic                  upd_write;

  logic [31:0] branch_cnt_q;
  logic [31:0] mispred_cnt_q;
  logic        mispredict;

  assign look_idx = bp.pc_if[INDEX_BITS+1:2];
  assign look_tag = bp.pc_if[31:INDEX_BITS+2];
  assign upd_idx  = bp.update_pc[INDEX_BITS+1:2];
  assign upd_tag  = bp.update_pc[31:INDEX_BITS+2];

  // Fetch lookup: reads registered table state, so a same-cycle update is
  // only visible from the next cycle on.
  always_comb begin
    look_e     = table_q[look_idx];
    look_hit   = look_e.valid && (look_e.tag == look_tag);
    look_taken = look_hit && look_e.cnt[1];
  end

  assign bp.pred_hit     = look_hit;
  assign bp.pred_taken   = look_taken;
  assign bp.pred_next_pc = look_taken ? look_e.target : bp.pc_if + 32'd4;

  // Flush request: wrong direction, or taken to a different target.
  assign mispredict = bp.update_valid &&
                      ((bp.update_taken != bp.update_pred_taken) ||
                       (bp.update_taken && (bp.update_pred_target != bp.update_target)));
  assign bp.mispredict = mispredict;
  assign bp.correct_pc = bp.update_taken ? bp.update_target : bp.update_pc + 32'd4;

  // Next value of the entry addressed by the resolving branch.
  // NOTE: every variable gets a default before the branches so no latch is inferred.
  always_comb begin
    upd_e     = table_q[upd_idx];
    upd_hit   = upd_e.valid && (upd_e.tag == upd_tag);
    upd_next  = upd_e;
    upd_write = 1'b0;
    if (upd_hit) begin
      upd_write = 1'b1;
      if (bp.update_taken) begin
        if (upd_e.cnt != 2'b11) upd_next.cnt = upd_e.cnt + 2'd1;
        upd_next.target = bp.update_target;
      end else if (upd_e.cnt != 2'b00) begin
        upd_next.cnt = upd_e.cnt - 2'd1;
      end
    end else if (bp.update_taken) begin
      // Allocation replaces whatever aliases at this index.
      upd_write = 1'b1;
      upd_next  = '{valid: 1'b1, tag: upd_tag, target: bp.update_target, cnt: CNT_ALLOC};
    end
  end

  // Table storage; a not-taken miss leaves the table untouched.
  // NOTE: the table is cleared by the asynchronous reset so no stale entry
  // can ever hit after reset; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: 2'b01};
      end
    end else if (bp.update_valid && upd_write) begin
      table_q[upd_idx] <= upd_next;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else if (bp.update_valid) begin
      if (branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + 32'd1;
      if (mispredict && (mispred_cnt_q != '1)) mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

  assign bp.branch_count     = branch_cnt_q;
  assign bp.mispredict_count = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus a
// randomized run, all compared against a table model indexed with plain
// arithmetic on the PC.
module tb_branch_predictor;

  logic clock = 1'b0;
  logic reset = 1'b0;

  branch_predictor_if bp ();

  branch_predictor #(
    .INDEX_BITS(4),
    .TAG_BITS  (26),
    .CNT_ALLOC (2'b10)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bp   (bp)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: 16 entries, index = (pc/4) mod 16, tag = pc/64.
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_cnt   [16];
  longint      m_br;
  longint      m_mp;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_cnt[i] = 1;
    end
    m_br = 0;
    m_mp = 0;
  endfunction

  // {hit, taken, next_pc}
  function automatic logic [33:0] exp_lookup(logic [31:0] pc);
    int i;
    bit hit, tk;
    i   = int'((pc / 4) % 16);
    hit = m_valid[i] && (m_tag[i] == pc / 64);
    tk  = hit && (m_cnt[i] >= 2);
    return {hit, tk, tk ? m_tgt[i] : pc + 32'd4};
  endfunction

  // {mispredict, correct_pc} from the currently driven EX inputs
  function automatic logic [32:0] exp_flush();
    bit mp;
    mp = bp.update_valid &&
         ((bp.update_taken != bp.update_pred_taken) ||
          (bp.update_taken && bp.update_pred_target != bp.update_target));
    return {mp, bp.update_taken ? bp.update_target : bp.update_pc + 32'd4};
  endfunction

  function automatic void model_update();
    int i;
    bit hit;
    logic [32:0] f;
    f   = exp_flush();
    i   = int'((bp.update_pc / 4) % 16);
    hit = m_valid[i] && (m_tag[i] == bp.update_pc / 64);
    if (hit) begin
      if (bp.update_taken) begin
        m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
        m_tgt[i] = bp.update_target;
      end else begin
        m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
      end
    end else if (bp.update_taken) begin
      m_valid[i] = 1;
      m_tag[i]   = bp.update_pc / 64;
      m_tgt[i]   = bp.update_target;
      m_cnt[i]   = 2;
    end
    if (m_br < 64'hFFFF_FFFF) m_br++;
    if (f[32] && m_mp < 64'hFFFF_FFFF) m_mp++;
  endfunction

  task automatic drive_update(input logic [31:0] pc, input bit taken, input logic [31:0] tgt,
                              input bit ptaken, input logic [31:0] ptgt);
    bp.update_valid       = 1'b1;
    bp.update_pc          = pc;
    bp.update_taken       = taken;
    bp.update_target      = tgt;
    bp.update_pred_taken  = ptaken;
    bp.update_pred_target = ptgt;
    #1;
  endtask

  // One clock: the model trains at the edge exactly when the DUT does.
  task automatic tick();
    @(posedge clock);
    if (bp.update_valid) model_update();
    @(negedge clock);
    bp.update_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [33:0] e;
    bp.pc_if = 32'h40; bp.update_valid = 1'b0; bp.update_pc = '0; bp.update_taken = 1'b0;
    bp.update_target = '0; bp.update_pred_taken = 1'b0; bp.update_pred_target = '0;
    reset = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({bp.branch_count, bp.mispredict_count} !== 64'd0) begin
      n_errors++;
      $display("FAIL reset_counters: got %h/%h, expected 0/0", bp.branch_count, bp.mispredict_count);
    end
    @(negedge clock);
    reset = 1'b1;
    tick();
    e = exp_lookup(bp.pc_if);
    n_checks++;
    if ({bp.pred_hit, bp.pred_taken, bp.pred_next_pc} !== e || e !== {2'b00, 32'h44}) begin
      n_errors++;
      $display("FAIL cold_lookup: got %h, expected %h", {bp.pred_hit, bp.pred_taken, bp.pred_next_pc}, e);
    end
  endtask

  task automatic test_cold_alloc();
    logic [33:0] e;
    logic [32:0] f;
    drive_update(32'h10, 1'b1, 32'h08, 1'b0, 32'h14);
    f = exp_flush();
    n_checks++;
    if ({bp.mispredict, bp.correct_pc} !== f || f !== {1'b1, 32'h08}) begin
      n_errors++;
      $display("FAIL alloc_flush: got %h, expected %h", {bp.mispredict, bp.correct_pc}, f);
    end
    tick();
    bp.pc_if = 32'h10;
    #1;
    e = exp_lookup(bp.pc_if);
    n_checks++;
    if ({bp.pred_hit, bp.pred_taken, bp.pred_next_pc} !== e || e !== {2'b11, 32'h08}) begin
      n_errors++;
      $display("FAIL alloc_lookup: got %h, expected %h", {bp.pred_hit, bp.pred_taken, bp.pred_next_pc}, e);
    end
    n_checks++;
    if (bp.branch_count !== 32'd1 || bp.mispredict_count !== 32'd1) begin
      n_errors++;
      $display("FAIL alloc_counts: got %0d/%0d, expected 1/1", bp.branch_count, bp.mispredict_count);
    end
  endtask

  task automatic test_saturation();
    logic [33:0] e;
    logic [32:0] f;
    bp.pc_if = 32'h10;
    for (int k = 0; k < 3; k++) begin
      drive_update(32'h10, 1'b1, 32'h08, 1'b1, 32'h08);
      tick();
    end
    // Two not-taken outcomes: first keeps the taken prediction, second flips it.
    for (int k = 0; k < 2; k++) begin
      drive_update(32'h10, 1'b0, 32'h08, bp.pred_taken, bp.pred_next_pc);
      f = exp_flush();
      n_checks++;
      if ({bp.mispredict, bp.correct_pc} !== f) begin
        n_errors++;
        $display("FAIL sat_flush_%0d: got %h, expected %h", k, {bp.mispredict, bp.correct_pc}, f);
      end
      tick();
      e = exp_lookup(bp.pc_if);
      n_checks++;
      if ({bp.pred_hit, bp.pred_taken, bp.pred_next_pc} !== e ||
          e !== ((k == 0) ? {2'b11, 32'h08} : {2'b10, 32'h14})) begin
        n_errors++;
        $display("FAIL sat_lookup_%0d: got %h, expected %h", k, {bp.pred_hit, bp.pred_taken, bp.pred_next_pc}, e);
      end
    end
  endtask

  task automatic test_not_taken_miss();
    logic [33:0] e;
    logic [32:0] f;
    logic [31:0] pcs [2];
    pcs[0] = 32'h20;
    pcs[1] = 32'hFFFF_FFFC;
    foreach (pcs[k]) begin
      drive_update(pcs[k], 1'b0, 32'h0, 1'b0, pcs[k] + 32'd4);
      f = exp_flush();
      n_checks++;
      if ({bp.mispredict, bp.correct_pc} !== f || f[32] !== 1'b0) begin
        n_errors++;
        $display("FAIL ntmiss_flush_%0d: got %h, expected %h", k, {bp.mispredict, bp.correct_pc}, f);
      end
      tick();
      bp.pc_if = pcs[k];
      #1;
      e = exp_lookup(bp.pc_if);
      n_checks++;
      if ({bp.pred_hit, bp.pred_taken, bp.pred_next_pc} !== e || e[33] !== 1'b0) begin
        n_errors++;
        $display("FAIL ntmiss_lookup_%0d: got %h, expected %h", k, {bp.pred_hit, bp.pred_taken, bp.pred_next_pc}, e);
      end
      n_checks++;
      if (bp.branch_count !== 32'(m_br)) begin
        n_errors++;
        $display("FAIL ntmiss_count_%0d: got %0d, expected %0d", k, bp.branch_count, m_br);
      end
    end
  endtask

  task automatic test_aliasing();
    logic [33:0] e;
    logic [32:0] f;
    drive_update(32'h50, 1'b1, 32'h100, 1'b0, 32'h54);
    tick();
    bp.pc_if = 32'h10;
    #1;
    e = exp_lookup(bp.pc_if);
    n_checks++;
    if ({bp.pred_hit, bp.pred_taken, bp.pred_next_pc} !== e || e[33] !== 1'b0) begin
      n_errors++;
      $display("FAIL alias_evicted: got %h, expected %h", {bp.pred_hit, bp.pred_taken, bp.pred_next_pc}, e);
    end
    bp.pc_if = 32'h50;
    #1;
    e = exp_lookup(bp.pc_if);
    n_checks++;
    if ({bp.pred_hit, bp.pred_taken, bp.pred_next_pc} !== e || e !== {2'b11, 32'h100}) begin
      n_errors++;
      $display("FAIL alias_new: got %h, expected %h", {bp.pred_hit, bp.pred_taken, bp.pred_next_pc}, e);
    end
    // Right direction, wrong target.
    drive_update(32'h50, 1'b1, 32'h200, 1'b1, 32'h100);
    f = exp_flush();
    n_checks++;
    if ({bp.mispredict, bp.correct_pc} !== f || f !== {1'b1, 32'h200}) begin
      n_errors++;
      $display("FAIL target_flush: got %h, expected %h", {bp.mispredict, bp.correct_pc}, f);
    end
    tick();
    e = exp_lookup(bp.pc_if);
    n_checks++;
    if ({bp.pred_hit, bp.pred_taken, bp.pred_next_pc} !== e || e !== {2'b11, 32'h200}) begin
      n_errors++;
      $display("FAIL target_lookup: got %h, expected %h", {bp.pred_hit, bp.pred_taken, bp.pred_next_pc}, e);
    end
  endtask

  task automatic test_same_cycle();
    logic [33:0] e;
    bp.pc_if = 32'h60;
    drive_update(32'h60, 1'b1, 32'h300, 1'b0, 32'h64);
    e = exp_lookup(bp.pc_if);
    n_checks++;
    if ({bp.pred_hit, bp.pred_taken, bp.pred_next_pc} !== e || e[33] !== 1'b0) begin
      n_errors++;
      $display("FAIL same_cycle_pre: got %h, expected %h", {bp.pred_hit, bp.pred_taken, bp.pred_next_pc}, e);
    end
    tick();
    e = exp_lookup(bp.pc_if);
    n_checks++;
    if ({bp.pred_hit, bp.pred_taken, bp.pred_next_pc} !== e || e !== {2'b11, 32'h300}) begin
      n_errors++;
      $display("FAIL same_cycle_post: got %h, expected %h", {bp.pred_hit, bp.pred_taken, bp.pred_next_pc}, e);
    end
  endtask

  // PCs drawn from a few tags over all 16 indices so aliasing is frequent.
  function automatic logic [31:0] rand_pc();
    logic [31:0] tags [4];
    tags[0] = 32'h0; tags[1] = 32'h1; tags[2] = 32'h2A; tags[3] = 32'h3FF_FFFF;
    return (tags[$urandom_range(0, 3)] << 6) | (32'($urandom_range(0, 15)) << 2);
  endfunction

  task automatic test_random();
    logic [33:0] e, p;
    logic [32:0] f;
    logic [31:0] upc;
    for (int n = 0; n < 400; n++) begin
      bp.pc_if = rand_pc();
      if ($urandom_range(0, 3) != 0) begin
        upc = rand_pc();
        p   = exp_lookup(upc);
        if ($urandom_range(0, 3) != 0)
          drive_update(upc, 1'($urandom), ($urandom_range(0, 1) != 0) ? p[31:0] : rand_pc(), p[32], p[31:0]);
        else
          drive_update(upc, 1'($urandom), rand_pc(), 1'($urandom), rand_pc());
      end else begin
        bp.update_valid = 1'b0;
        bp.update_pc    = rand_pc();
        #1;
      end
      e = exp_lookup(bp.pc_if);
      n_checks++;
      if ({bp.pred_hit, bp.pred_taken, bp.pred_next_pc} !== e) begin
        n_errors++;
        $display("FAIL rand_lookup_%0d: pc=%h got %h, expected %h", n, bp.pc_if,
                 {bp.pred_hit, bp.pred_taken, bp.pred_next_pc}, e);
      end
      f = exp_flush();
      n_checks++;
      if ({bp.mispredict, bp.correct_pc} !== f) begin
        n_errors++;
        $display("FAIL rand_flush_%0d: got %h, expected %h", n, {bp.mispredict, bp.correct_pc}, f);
      end
      tick();
      n_checks++;
      if ({bp.branch_count, bp.mispredict_count} !== {32'(m_br), 32'(m_mp)}) begin
        n_errors++;
        $display("FAIL rand_counts_%0d: got %0d/%0d, expected %0d/%0d", n,
                 bp.branch_count, bp.mispredict_count, m_br, m_mp);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [33:0] e;
    drive_update(32'h80, 1'b1, 32'h400, 1'b0, 32'h84);
    tick();
    bp.pc_if = 32'h80;
    #1;
    e = exp_lookup(bp.pc_if);
    n_checks++;
    if ({bp.pred_hit, bp.pred_taken, bp.pred_next_pc} !== e || e[33] !== 1'b1) begin
      n_errors++;
      $display("FAIL pre_reset_hit: got %h, expected %h", {bp.pred_hit, bp.pred_taken, bp.pred_next_pc}, e);
    end
    // Assert reset between edges; effects must appear without a clock edge.
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    e = exp_lookup(bp.pc_if);
    n_checks++;
    if ({bp.pred_hit, bp.pred_taken, bp.pred_next_pc} !== e || e[33] !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset_lookup: got %h, expected %h", {bp.pred_hit, bp.pred_taken, bp.pred_next_pc}, e);
    end
    n_checks++;
    if ({bp.branch_count, bp.mispredict_count} !== 64'd0) begin
      n_errors++;
      $display("FAIL async_reset_counts: got %0d/%0d, expected 0/0", bp.branch_count, bp.mispredict_count);
    end
    @(negedge clock);
    reset = 1'b1;
    tick();
    for (int k = 0; k < 16; k++) begin
      bp.pc_if = rand_pc();
      #1;
      e = exp_lookup(bp.pc_if);
      n_checks++;
      if ({bp.pred_hit, bp.pred_taken, bp.pred_next_pc} !== e) begin
        n_errors++;
        $display("FAIL post_reset_lookup_%0d: got %h, expected %h", k,
                 {bp.pred_hit, bp.pred_taken, bp.pred_next_pc}, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_cold_alloc();
    test_saturation();
    test_not_taken_miss();
    test_aliasing();
    test_same_cycle();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
